wb_dbg_master: RTL and testbench
================================

# wb_dbg_master

Serial debug bridge that turns byte commands from a UART byte stream into single 32-bit Wishbone master transactions, giving a host PC direct read/write access to any slave on the interconnect (BRAM, SRAM, UART, timer, GPIO).
- It connects to a spare master port of the Wishbone interconnect, alongside the LM32 instruction and data masters.
- It connects on the byte side to a UART core's receive/transmit byte interface.

## Interface
Parameters:
- bus_timeout, default 1024: number of cycles that stb may wait for ack/err before the transaction is aborted.
- byte_timeout, default 5000000: maximum number of idle cycles allowed between bytes of one command frame.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  reset, synchronous, active-low.
- rx_dat  in  8  received byte; valid only while rx_avail=1.
- rx_avail  in  1  one-cycle pulse; a new byte is present on rx_dat.
- tx_dat  out  8  byte to transmit.
- tx_wr  out  1  one-cycle pulse that loads tx_dat into the UART.
- tx_busy  in  1  UART transmitter busy.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_sel_o  out  4  byte select; always 4'hF.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.
- busy  out  1  high in every state except IDLE.

## Operation
Frame format (multi-byte fields MSB first):
- Write frame: 0x01, A3..A0, D3..D0.
- Read frame: 0x02, A3..A0.
- Any other command byte in IDLE: discarded silently, no response, stay in IDLE.

State machine:
- IDLE: rx byte 0x01 → ADDR with we=1; rx byte 0x02 → ADDR with we=0.
- ADDR: collect 4 address bytes into wb_adr_o (shift left by 8, insert the new byte at bits [7:0]). After the 4th byte: write → WDATA, read → BUS.
- WDATA: collect 4 bytes into wb_dat_o the same way. After the 4th byte → BUS.
- BUS: cyc=stb=1, we as latched, sel=4'hF.
  - ack → latch wb_dat_i (reads only), go to RESP; result OK.
  - err → RESP; result ERR.
  - Timeout (stb high for bus_timeout cycles, no ack/err) → RESP; result ERR.
  - ack and err in the same cycle: err wins.
- RESP: send the response, then return to IDLE.
  - Write OK: one byte 0xAA.
  - Read OK: 4 bytes, read data MSB first.
  - ERR: one byte 0xEE.

Boundary rules:
- Inter-byte timeout: in ADDR or WDATA, if byte_timeout cycles pass with no rx_avail, return to IDLE. No bus cycle, no response.
- rx_avail while in BUS or RESP: the byte is dropped.
- Byte counter is 2 bits and wraps from 3 to 0 on each field transition.
- The timeout counter clears on entry to BUS. The byte-timeout counter clears on every rx_avail.

Reset values (all outputs): wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=4'hF, tx_wr=0, tx_dat=0, busy=0; state IDLE.
- A reset asserted mid-transaction drops cyc/stb at that clock edge and sends no response.

## Timing
- All outputs are registered.
- Bus start: cyc/stb rise on the edge after the cycle in which the last frame byte's rx_avail is sampled.
- Bus end: the clock edge that samples ack or err (or the timeout) deasserts cyc/stb, so the strobe lasts ≥1 cycle. A zero-wait slave acking in the first stb cycle gives exactly 1 cycle of cyc/stb.
- Read data is captured on the same edge that samples ack.
- tx_wr pulses for exactly one cycle, only when tx_busy=0 and tx_wr was 0 in the previous cycle. This guard cycle covers the UART's one-cycle busy latency.
- First response byte: tx_wr can occur in the first RESP cycle, i.e. 1 cycle after the bus cycle ends.
- tx_dat is stable from the tx_wr pulse until the next tx_wr.
- Return to IDLE: one cycle after the last response tx_wr. busy falls on that same edge.
- Frame acceptance: a new frame is accepted from the cycle busy=0.

## Test plan
- Write: send 01 00 00 00 10 DE AD BE EF; slave acks after 2 wait cycles → one write cycle with adr=0x00000010, dat=0xDEADBEEF, we=1, sel=F, stb high 3 cycles; tx byte 0xAA.
- Read, zero-wait slave returning 0x12345678 at adr 0x70000000 → stb high exactly 1 cycle, we=0; tx bytes 12 34 56 78 in order, each tx_wr issued only with tx_busy low.
- Error and timeout: err asserted with ack in the same cycle → tx 0xEE. With bus_timeout=16 and no ack → stb drops after 16 cycles, tx 0xEE, busy falls.
- Aborted frame: send 01 00 00, then idle for byte_timeout cycles → back to IDLE, no cyc, no tx. A following valid read then completes normally.
- Unknown command 0x55, and bytes sent during BUS/RESP → ignored; no cyc, no extra tx; the next valid frame works.
- Reset during BUS (reset_n low one cycle) → cyc/stb/busy=0 at the next edge, no response; the next frame works.

Source files
------------

// File: rtl/wb_dbg_master_if.sv
// Byte-stream and Wishbone signal bundle for the serial debug bridge.
// The master modport is the bridge itself; the slave modport is the UART/interconnect side.
interface wb_dbg_master_if;
  logic [7:0]  rx_dat;
  logic        rx_avail;
  logic [7:0]  tx_dat;
  logic        tx_wr;
  logic        tx_busy;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        busy;

  modport master (
    input  rx_dat, rx_avail, tx_busy, wb_dat_i, wb_ack_i, wb_err_i,
    output tx_dat, tx_wr, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy
  );

  modport slave (
    output rx_dat, rx_avail, tx_busy, wb_dat_i, wb_ack_i, wb_err_i,
    input  tx_dat, tx_wr, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy
  );
endinterface

// File: rtl/wb_dbg_master.sv
// Serial debug bridge: byte-framed read/write commands from a UART become single
// 32-bit Wishbone transactions, answered with a status byte or the read data.
module wb_dbg_master #(
  parameter int bus_timeout  = 1024,
  parameter int byte_timeout = 5000000
) (
  input logic             clk,
  input logic             reset_n,
  wb_dbg_master_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] BUS   = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam int BUS_W  = $clog2(bus_timeout + 1);
  localparam int BYTE_W = $clog2(byte_timeout + 1);
  localparam logic [BUS_W-1:0]  BUS_LAST  = BUS_W'(bus_timeout - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(byte_timeout - 1);

  logic [2:0]        state;
  logic [1:0]        byte_idx;
  logic [BYTE_W-1:0] idle_cnt;
  logic [BUS_W-1:0]  bus_cnt;
  logic [31:0]       adr_q;
  logic [31:0]       dat_q;
  logic              we_q;
  logic              cyc_q;
  logic [31:0]       tx_shift;   // response bytes, next one in [31:24]
  logic [2:0]        tx_left;
  logic              tx_wr_q;
  logic [7:0]        tx_dat_q;
  logic              busy_q;

  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_sel_o = 4'hF;
  assign bus.tx_wr    = tx_wr_q;
  assign bus.tx_dat   = tx_dat_q;
  assign bus.busy     = busy_q;

  // NOTE: every register here uses <= so all updates see the pre-edge values,
  // which is what makes the one-cycle tx_wr guard and the shift registers correct.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: datapath registers are reset too because they drive outputs
      // whose reset values are observable on the bus and UART side.
      state    <= IDLE;
      byte_idx <= 2'd0;
      idle_cnt <= '0;
      bus_cnt  <= '0;
      adr_q    <= 32'd0;
      dat_q    <= 32'd0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      tx_shift <= 32'd0;
      tx_left  <= 3'd0;
      tx_wr_q  <= 1'b0;
      tx_dat_q <= 8'd0;
      busy_q   <= 1'b0;
    end else begin
      tx_wr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_avail && (bus.rx_dat == 8'h01 || bus.rx_dat == 8'h02)) begin
            we_q     <= (bus.rx_dat == 8'h01);
            state    <= ADDR;
            busy_q   <= 1'b1;
            byte_idx <= 2'd0;
            idle_cnt <= '0;
          end
        end

        ADDR, WDATA: begin
          if (bus.rx_avail) begin
            idle_cnt <= '0;
            byte_idx <= byte_idx + 2'd1;
            if (state == ADDR) adr_q <= {adr_q[23:0], bus.rx_dat};
            else               dat_q <= {dat_q[23:0], bus.rx_dat};
            if (byte_idx == 2'd3) begin
              if (state == ADDR && we_q) begin
                state <= WDATA;
              end else begin
                state   <= BUS;
                cyc_q   <= 1'b1;
                bus_cnt <= '0;
              end
            end
          end else if (idle_cnt == BYTE_LAST) begin
            // Host went quiet mid-frame: abandon it without touching the bus.
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        BUS: begin
          // err is tested first so that a simultaneous ack/err reports an error.
          if (bus.wb_err_i || (!bus.wb_ack_i && bus_cnt == BUS_LAST)) begin
            cyc_q    <= 1'b0;
            state    <= RESP;
            tx_shift <= {8'hEE, 24'd0};
            tx_left  <= 3'd1;
          end else if (bus.wb_ack_i) begin
            cyc_q    <= 1'b0;
            state    <= RESP;
            tx_shift <= we_q ? {8'hAA, 24'd0} : bus.wb_dat_i;
            tx_left  <= we_q ? 3'd1 : 3'd4;
          end else begin
            bus_cnt <= bus_cnt + 1'b1;
          end
        end

        RESP: begin
          if (tx_wr_q && tx_left == 3'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (!bus.tx_busy && !tx_wr_q) begin
            // The UART raises tx_busy one cycle late, so a write is never
            // issued right after another one.
            tx_wr_q  <= 1'b1;
            tx_dat_q <= tx_shift[31:24];
            tx_shift <= {tx_shift[23:0], 8'd0};
            tx_left  <= tx_left - 3'd1;
          end
        end

        default: begin
          state  <= IDLE;
          cyc_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dbg_master.sv
// Scoreboard bench for wb_dbg_master: stimulus pushes expected bus cycles and tx
// bytes; a monitor on the falling edge pops and compares them as the DUT produces them.
module tb_wb_dbg_master;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_dbg_master_if dif ();

  wb_dbg_master #(
    .bus_timeout  (16),
    .byte_timeout (64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.master)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
    logic        chk_dat;
  } bus_exp_t;

  bus_exp_t   exp_bus[$];
  logic [7:0] exp_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Wishbone slave: mode 0 = never answers, 1 = ack, 2 = ack and err together.
  int          s_mode  = 0;
  int          s_wait  = 0;
  logic [31:0] s_rdata = 32'd0;
  int          s_cnt   = 0;

  assign dif.wb_ack_i = dif.wb_stb_o && (s_mode == 1 || s_mode == 2) && (s_cnt == s_wait);
  assign dif.wb_err_i = dif.wb_stb_o && (s_mode == 2) && (s_cnt == s_wait);
  assign dif.wb_dat_i = s_rdata;

  always @(posedge clk) begin
    if (!dif.wb_stb_o || dif.wb_ack_i || dif.wb_err_i) s_cnt <= 0;
    else                                               s_cnt <= s_cnt + 1;
  end

  // UART transmitter: busy rises one cycle after tx_wr and stays up for 6 cycles.
  int u_cnt = 0;
  assign dif.tx_busy = (u_cnt != 0);

  always @(posedge clk) begin
    if (!reset_n)       u_cnt <= 0;
    else if (dif.tx_wr) u_cnt <= 6;
    else if (u_cnt != 0) u_cnt <= u_cnt - 1;
  end

  // Monitor
  int          stb_len = 0;
  logic [31:0] m_adr, m_dat;
  logic        m_we;
  logic [3:0]  m_sel;
  logic        prev_busy = 1'b0;
  logic        prev_wr   = 1'b0;
  bus_exp_t    m_exp;

  always @(negedge clk) begin
    if (dif.wb_stb_o) begin
      stb_len++;
      m_adr = dif.wb_adr_o;
      m_dat = dif.wb_dat_o;
      m_we  = dif.wb_we_o;
      m_sel = dif.wb_sel_o;
      check("cyc_eq_stb", 32'(dif.wb_cyc_o), 32'd1);
    end else if (stb_len > 0) begin
      if (exp_bus.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bus_cycle: got adr 0x%08h len %0d expected none", m_adr, stb_len);
      end else begin
        m_exp = exp_bus.pop_front();
        check("bus_adr", m_adr, m_exp.adr);
        check("bus_we", 32'(m_we), 32'(m_exp.we));
        check("bus_sel", 32'(m_sel), 32'hF);
        check("bus_stb_len", 32'(stb_len), 32'(m_exp.len));
        if (m_exp.chk_dat) check("bus_dat", m_dat, m_exp.dat);
      end
      stb_len = 0;
    end

    if (dif.tx_wr) begin
      check("tx_busy_guard", 32'(prev_busy), 32'd0);
      check("tx_wr_pulse", 32'(prev_wr), 32'd0);
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got 0x%02h expected none", dif.tx_dat);
      end else begin
        check("tx_dat", 32'(dif.tx_dat), 32'(exp_tx.pop_front()));
      end
    end
    prev_busy = dif.tx_busy;
    prev_wr   = dif.tx_wr;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dif.rx_dat   = b;
    dif.rx_avail = 1'b1;
    @(negedge clk);
    dif.rx_avail = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  // Strobe must already be up one cycle after the last frame byte was sampled.
  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat);
    send_byte(8'h01);
    send_word(adr);
    send_word(dat);
    check("bus_start_wr", 32'(dif.wb_stb_o), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] adr);
    send_byte(8'h02);
    send_word(adr);
    check("bus_start_rd", 32'(dif.wb_stb_o), 32'd1);
  endtask

  task automatic push_bus(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                          input int len, input logic chk_dat);
    bus_exp_t e;
    e.adr = adr; e.dat = dat; e.we = we; e.len = len; e.chk_dat = chk_dat;
    exp_bus.push_back(e);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((dif.busy || exp_bus.size() != 0 || exp_tx.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy %0b pending bus %0d tx %0d expected all idle",
               name, dif.busy, exp_bus.size(), exp_tx.size());
    end else begin
      check({name, "_busy"}, 32'(dif.busy), 32'd0);
    end
    tick(2);
  endtask

  initial begin
    reset_n      = 1'b0;
    dif.rx_dat   = 8'd0;
    dif.rx_avail = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    check("rst_cyc", 32'(dif.wb_cyc_o), 32'd0);
    check("rst_stb", 32'(dif.wb_stb_o), 32'd0);
    check("rst_we", 32'(dif.wb_we_o), 32'd0);
    check("rst_adr", dif.wb_adr_o, 32'd0);
    check("rst_dat", dif.wb_dat_o, 32'd0);
    check("rst_sel", 32'(dif.wb_sel_o), 32'hF);
    check("rst_tx_wr", 32'(dif.tx_wr), 32'd0);
    check("rst_tx_dat", 32'(dif.tx_dat), 32'd0);
    check("rst_busy", 32'(dif.busy), 32'd0);

    // Write, two wait states: stb high 3 cycles, reply 0xAA.
    s_mode = 1; s_wait = 2;
    push_bus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 3, 1'b1);
    exp_tx.push_back(8'hAA);
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    wait_idle("write");

    // Zero-wait read: stb high 1 cycle, four data bytes MSB first.
    s_mode = 1; s_wait = 0; s_rdata = 32'h1234_5678;
    push_bus(32'h7000_0000, 32'd0, 1'b0, 1, 1'b0);
    push_word(32'h1234_5678);
    do_read(32'h7000_0000);
    wait_idle("read");

    // ack and err in the same cycle: error response.
    s_mode = 2; s_wait = 0;
    push_bus(32'h0000_0020, 32'h55AA_0011, 1'b1, 1, 1'b1);
    exp_tx.push_back(8'hEE);
    do_write(32'h0000_0020, 32'h55AA_0011);
    wait_idle("ack_err");

    // Silent slave: stb dropped after 16 cycles, error response.
    s_mode = 0;
    push_bus(32'h3000_0004, 32'd0, 1'b0, 16, 1'b0);
    exp_tx.push_back(8'hEE);
    do_read(32'h3000_0004);
    wait_idle("bus_timeout");

    // Partial frame abandoned after the inter-byte timeout.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    check("abort_busy_mid", 32'(dif.busy), 32'd1);
    tick(70);
    check("abort_busy_after", 32'(dif.busy), 32'd0);
    check("abort_cyc", 32'(dif.wb_cyc_o), 32'd0);
    s_mode = 1; s_wait = 1; s_rdata = 32'hA5A5_0F0F;
    push_bus(32'h0000_0100, 32'd0, 1'b0, 2, 1'b0);
    push_word(32'hA5A5_0F0F);
    do_read(32'h0000_0100);
    wait_idle("after_abort");

    // Unknown command byte is ignored.
    send_byte(8'h55);
    tick(2);
    check("unknown_cmd_busy", 32'(dif.busy), 32'd0);

    // Bytes arriving during BUS are dropped.
    s_mode = 1; s_wait = 4;
    push_bus(32'h0000_0040, 32'h0102_0304, 1'b1, 5, 1'b1);
    exp_tx.push_back(8'hAA);
    do_write(32'h0000_0040, 32'h0102_0304);
    send_byte(8'h02);
    send_byte(8'h01);
    wait_idle("drop_in_bus");

    // Bytes arriving during RESP are dropped.
    s_mode = 1; s_wait = 0; s_rdata = 32'hCAFE_F00D;
    push_bus(32'h0000_0200, 32'd0, 1'b0, 1, 1'b0);
    push_word(32'hCAFE_F00D);
    do_read(32'h0000_0200);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h02);
    wait_idle("drop_in_resp");

    // Reset pulse while the strobe is up: cycle cut short, no response.
    s_mode = 0;
    push_bus(32'h0000_0050, 32'd0, 1'b0, 3, 1'b0);
    do_read(32'h0000_0050);
    tick(2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("reset_mid_cyc", 32'(dif.wb_cyc_o), 32'd0);
    check("reset_mid_stb", 32'(dif.wb_stb_o), 32'd0);
    check("reset_mid_busy", 32'(dif.busy), 32'd0);
    tick(20);
    s_mode = 1; s_wait = 3; s_rdata = 32'h0BAD_C0DE;
    push_bus(32'hFFFF_FFFC, 32'd0, 1'b0, 4, 1'b0);
    push_word(32'h0BAD_C0DE);
    do_read(32'hFFFF_FFFC);
    wait_idle("after_reset");

    check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
